// File: rtl/io_read_port_buffer_if.sv
// Producer/read-stage handshake bundle for io_read_port_buffer.
// master = producer + read stage side, slave = buffer side.
interface io_read_port_buffer_if #(
  parameter int WORD_WIDTH = 36
);
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_full;
  logic                  out_rden;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_full,
    output out_rden
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_full,
    input  out_rden
  );
endinterface

// File: rtl/io_read_port_buffer.sv
// Per-port input FIFO feeding the I/O read stage EmptyFull/data_IO slice.
// Optional sticky overflow/underflow flag: define IO_READ_BUFFER_ERROR_EN.
module io_read_port_buffer #(
  parameter int WORD_WIDTH  = 36,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  io_read_port_buffer_if.slave   port,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   error
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wp;
  logic [PTR_WIDTH-1:0]  rp;
  logic                  push;
  logic                  pop;

  // Status comes only from registered count, so the read stage sees a stable Full bit.
  assign port.in_ready = (count != FULL_COUNT);
  assign port.out_full = (count != '0);
  assign port.out_data = port.out_full ? mem[rp] : '0;

  assign push = port.in_valid & port.in_ready;
  assign pop  = port.out_rden & port.out_full;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wp] <= port.in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + PTR_WIDTH'(1);
      end
      if (pop) begin
        rp <= rp + PTR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_WIDTH'(1);
        2'b01:   count <= count - COUNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IO_READ_BUFFER_ERROR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      error <= 1'b0;
    end else if ((port.out_rden & ~port.out_full) | (port.in_valid & ~port.in_ready)) begin
      error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
